// File: rtl/usb_pkg.sv
// Shared USB definitions: handshake/data PIDs and the IN endpoint state encoding.
package usb_pkg;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [2:0] {
    ST_FILL     = 3'd0,
    ST_READY    = 3'd1,
    ST_SENDING  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_STALLED  = 3'd4
  } ep_state_e;

  function automatic logic [3:0] data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_in_ep_buffer.sv
// Single-packet IN endpoint buffer: the application fills a packet, the host
// pulls it with IN tokens, and the data toggle advances only on a host ACK.
module usb_in_ep_buffer #(
  parameter int unsigned MAX_PKT     = 32,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_data_free,
  output logic       in_ep_acked,
  input  logic       in_token_rx,
  input  logic       setup_token_rx,
  input  logic       ack_rx,
  output logic       tx_pid_start,
  output logic [3:0] tx_pid,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data
);
  import usb_pkg::*;

  localparam int unsigned AW = $clog2(MAX_PKT);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  ep_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          toggle_q, toggle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pid_start_q, pid_start_d;
  logic [3:0]    pid_q, pid_d;
  logic          acked_q, acked_d;
  logic          wr_en;

  logic [7:0] mem [MAX_PKT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      toggle_q    <= 1'b0;
      tmo_q       <= '0;
      pid_start_q <= 1'b0;
      pid_q       <= '0;
      acked_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      toggle_q    <= toggle_d;
      tmo_q       <= tmo_d;
      pid_start_q <= pid_start_d;
      pid_q       <= pid_d;
      acked_q     <= acked_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[AW-1:0]] <= in_ep_data;
  end

  assign in_ep_data_free = (state_q == ST_FILL) && (count_q < CW'(MAX_PKT));
  assign tx_data_avail   = (state_q == ST_SENDING) && (rd_ptr_q < count_q);
  assign tx_data         = mem[rd_ptr_q[AW-1:0]];
  assign tx_pid_start    = pid_start_q;
  assign tx_pid          = pid_q;
  assign in_ep_acked     = acked_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    toggle_d    = toggle_q;
    tmo_d       = tmo_q;
    pid_start_d = 1'b0;
    pid_d       = pid_q;
    acked_d     = 1'b0;
    wr_en       = 1'b0;

    // SETUP beats STALL, and STALL beats every per-state event.
    if (setup_token_rx) begin
      state_d  = ST_FILL;
      count_d  = '0;
      rd_ptr_d = '0;
      toggle_d = 1'b1;
      tmo_d    = '0;
    end else if (in_ep_stall) begin
      state_d = ST_STALLED;
      count_d = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_token_rx) begin
            pid_start_d = 1'b1;
            pid_d       = PID_NAK;
          end
          if (in_ep_data_put && in_ep_data_free) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (in_ep_data_done || (count_d == CW'(MAX_PKT))) state_d = ST_READY;
        end
        ST_READY: begin
          if (in_token_rx) begin
            pid_start_d = 1'b1;
            pid_d       = data_pid(toggle_q);
            rd_ptr_d    = '0;
            state_d     = ST_SENDING;
          end
        end
        ST_SENDING: begin
          if (rd_ptr_q == count_q) begin
            state_d = ST_WAIT_ACK;
            tmo_d   = '0;
          end else if (tx_data_get) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_rx) begin
            toggle_d = ~toggle_q;
            count_d  = '0;
            acked_d  = 1'b1;
            state_d  = ST_FILL;
          end else if (in_token_rx) begin
            pid_start_d = 1'b1;
            pid_d       = data_pid(toggle_q);
            rd_ptr_d    = '0;
            state_d     = ST_SENDING;
          end else if (tmo_q == TW'(ACK_TIMEOUT)) begin
            state_d = ST_READY;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        ST_STALLED: begin
          if (in_token_rx) begin
            pid_start_d = 1'b1;
            pid_d       = PID_STALL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_in_ep_buffer.sv
// Randomized bench for usb_in_ep_buffer against a packet-level endpoint model.
module tb_usb_in_ep_buffer;

  localparam int unsigned MAX = 32;
  localparam int unsigned TMO = 1023;

  logic       clk, reset;
  logic       in_ep_data_put, in_ep_data_done, in_ep_stall;
  logic [7:0] in_ep_data;
  logic       in_ep_data_free, in_ep_acked;
  logic       in_token_rx, setup_token_rx, ack_rx;
  logic       tx_pid_start, tx_data_avail, tx_data_get;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;

  int checks   = 0;
  int failures = 0;

  logic       exp_toggle;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit         rx_hung;

  usb_in_ep_buffer #(.MAX_PKT(MAX), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall),
    .in_ep_data_free(in_ep_data_free), .in_ep_acked(in_ep_acked),
    .in_token_rx(in_token_rx), .setup_token_rx(setup_token_rx), .ack_rx(ack_rx),
    .tx_pid_start(tx_pid_start), .tx_pid(tx_pid),
    .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get), .tx_data(tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  function automatic logic [3:0] exp_data_pid(input logic t);
    return t ? 4'hB : 4'h3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_toggle = 1'b0;
    exp_q.delete();
  endtask

  task automatic put_byte(input logic [7:0] b, input logic with_done);
    in_ep_data_put  = 1'b1;
    in_ep_data      = b;
    in_ep_data_done = with_done;
    tick();
    in_ep_data_put  = 1'b0;
    in_ep_data_done = 1'b0;
  endtask

  task automatic put_bytes(input int unsigned n, input bit done_last);
    logic [7:0] b;
    for (int unsigned i = 0; i < n; i++) begin
      b = 8'($urandom);
      put_byte(b, done_last && (i == n - 1));
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_done();
    in_ep_data_done = 1'b1;
    tick();
    in_ep_data_done = 1'b0;
  endtask

  task automatic in_token(output logic st, output logic [3:0] pid);
    in_token_rx = 1'b1;
    tick();
    in_token_rx = 1'b0;
    st  = tx_pid_start;
    pid = tx_pid;
  endtask

  // Pull bytes with random gaps until avail drops, then let the DUT reach WAIT_ACK.
  task automatic receive();
    rx_q.delete();
    rx_hung = 1'b1;
    for (int i = 0; i < 8 * MAX + 8; i++) begin
      if (!tx_data_avail) begin
        rx_hung = 1'b0;
        break;
      end
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end else begin
        rx_q.push_back(tx_data);
        tx_data_get = 1'b1;
        tick();
        tx_data_get = 1'b0;
      end
    end
    tick();
  endtask

  task automatic send_ack(output logic a);
    ack_rx = 1'b1;
    tick();
    ack_rx = 1'b0;
    a = in_ep_acked;
  endtask

  task automatic compare_packet(input string tag);
    checks++;
    if (rx_hung !== 1'b0) begin
      failures++;
      $display("FAIL %s_rx_bound got=hung exp=done", tag);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_len got=%0d exp=%0d", tag, rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s_byte[%0d] got=%h exp=%h", tag, i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ep_data_free !== 1'b1) begin failures++; $display("FAIL rst_free got=%b exp=1", in_ep_data_free); end
    checks++; if (tx_pid_start !== 1'b0) begin failures++; $display("FAIL rst_pid_start got=%b exp=0", tx_pid_start); end
    checks++; if (tx_pid !== 4'h0) begin failures++; $display("FAIL rst_pid got=%h exp=0", tx_pid); end
    checks++; if (in_ep_acked !== 1'b0) begin failures++; $display("FAIL rst_acked got=%b exp=0", in_ep_acked); end
    checks++; if (tx_data_avail !== 1'b0) begin failures++; $display("FAIL rst_avail got=%b exp=0", tx_data_avail); end
  endtask

  task automatic test_basic();
    logic st, a;
    logic [3:0] pid;
    apply_reset();
    exp_q = '{8'h12, 8'h01};
    put_byte(8'h12, 1'b0);
    put_byte(8'h01, 1'b0);
    pulse_done();
    in_token(st, pid);
    checks++; if (st !== 1'b1 || pid !== 4'h3) begin failures++; $display("FAIL basic_pid got=%b/%h exp=1/3", st, pid); end
    receive();
    compare_packet("basic");
    send_ack(a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL basic_acked got=%b exp=1", a); end
    tick();
    checks++; if (in_ep_acked !== 1'b0) begin failures++; $display("FAIL basic_acked_pulse got=%b exp=0", in_ep_acked); end
    exp_toggle = ~exp_toggle;
    exp_q.delete();
    put_bytes(1, 1'b1);
    in_token(st, pid);
    checks++; if (pid !== 4'hB) begin failures++; $display("FAIL basic_pid2 got=%h exp=b", pid); end
    receive();
    compare_packet("basic2");
    send_ack(a);
    exp_toggle = ~exp_toggle;
  endtask

  task automatic test_zlp();
    logic st, a;
    logic [3:0] pid;
    bit saw_avail;
    apply_reset();
    pulse_done();
    in_token(st, pid);
    checks++; if (st !== 1'b1 || pid !== 4'h3) begin failures++; $display("FAIL zlp_pid got=%b/%h exp=1/3", st, pid); end
    saw_avail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tx_data_avail) saw_avail = 1'b1;
      tick();
    end
    checks++; if (saw_avail !== 1'b0) begin failures++; $display("FAIL zlp_avail got=%b exp=0", saw_avail); end
    send_ack(a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL zlp_acked got=%b exp=1", a); end
    exp_toggle = ~exp_toggle;
  endtask

  task automatic test_nak_and_full();
    logic st, a;
    logic [3:0] pid;
    apply_reset();
    put_bytes(3, 1'b0);
    in_token(st, pid);
    checks++; if (st !== 1'b1 || pid !== 4'hA) begin failures++; $display("FAIL nak_pid got=%b/%h exp=1/a", st, pid); end
    tick();
    checks++; if (tx_pid_start !== 1'b0) begin failures++; $display("FAIL nak_pulse got=%b exp=0", tx_pid_start); end
    checks++; if (in_ep_data_free !== 1'b1) begin failures++; $display("FAIL nak_free got=%b exp=1", in_ep_data_free); end
    put_bytes(MAX - 3, 1'b0);
    checks++; if (in_ep_data_free !== 1'b0) begin failures++; $display("FAIL full_free got=%b exp=0", in_ep_data_free); end
    put_byte(8'hEE, 1'b0);
    checks++; if (in_ep_data_free !== 1'b0) begin failures++; $display("FAIL full_free2 got=%b exp=0", in_ep_data_free); end
    in_token(st, pid);
    checks++; if (pid !== exp_data_pid(exp_toggle)) begin failures++; $display("FAIL full_pid got=%h exp=%h", pid, exp_data_pid(exp_toggle)); end
    receive();
    compare_packet("full");
    send_ack(a);
    exp_toggle = ~exp_toggle;
  endtask

  task automatic test_timeout();
    logic st, a;
    logic [3:0] pid;
    exp_q.delete();
    put_bytes(MAX, 1'b0);
    in_token(st, pid);
    receive();
    compare_packet("tmo_first");
    in_token(st, pid);
    checks++; if (st !== 1'b1 || pid !== exp_data_pid(exp_toggle)) begin failures++; $display("FAIL resend_pid got=%b/%h exp=1/%h", st, pid, exp_data_pid(exp_toggle)); end
    receive();
    compare_packet("resend");
    repeat (TMO + 80) tick();
    send_ack(a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL tmo_ack_ignored got=%b exp=0", a); end
    in_token(st, pid);
    checks++; if (st !== 1'b1 || pid !== exp_data_pid(exp_toggle)) begin failures++; $display("FAIL tmo_pid got=%b/%h exp=1/%h", st, pid, exp_data_pid(exp_toggle)); end
    receive();
    compare_packet("tmo_resend");
    repeat (TMO - 30) tick();
    send_ack(a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL tmo_early_ack got=%b exp=1", a); end
    exp_toggle = ~exp_toggle;
  endtask

  task automatic test_stall();
    logic st, a;
    logic [3:0] pid;
    exp_q.delete();
    put_bytes(3, 1'b0);
    in_ep_stall = 1'b1;
    tick();
    in_ep_stall = 1'b0;
    checks++; if (in_ep_data_free !== 1'b0) begin failures++; $display("FAIL stall_free got=%b exp=0", in_ep_data_free); end
    put_byte(8'h55, 1'b1);
    in_token(st, pid);
    checks++; if (st !== 1'b1 || pid !== 4'hE) begin failures++; $display("FAIL stall_pid got=%b/%h exp=1/e", st, pid); end
    send_ack(a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL stall_ack got=%b exp=0", a); end
    setup_token_rx = 1'b1;
    in_ep_stall    = 1'b1;
    tick();
    setup_token_rx = 1'b0;
    in_ep_stall    = 1'b0;
    checks++; if (in_ep_data_free !== 1'b1) begin failures++; $display("FAIL setup_free got=%b exp=1", in_ep_data_free); end
    exp_toggle = 1'b1;
    exp_q.delete();
    put_bytes(2, 1'b1);
    in_token(st, pid);
    checks++; if (pid !== 4'hB) begin failures++; $display("FAIL setup_pid got=%h exp=b", pid); end
    receive();
    compare_packet("setup");
    send_ack(a);
    exp_toggle = ~exp_toggle;
  endtask

  task automatic test_random_packets();
    logic st, a;
    logic [3:0] pid;
    int unsigned len, first;
    bit dl;
    for (int n = 0; n < 14; n++) begin
      exp_q.delete();
      len   = $urandom_range(0, MAX);
      first = $urandom_range(0, len);
      put_bytes(first, 1'b0);
      if (first < MAX) begin
        in_token(st, pid);
        checks++; if (st !== 1'b1 || pid !== 4'hA) begin failures++; $display("FAIL rnd_nak got=%b/%h exp=1/a", st, pid); end
      end
      dl = (len < MAX) && (len > first) && ($urandom_range(0, 1) == 1);
      put_bytes(len - first, dl);
      if (len < MAX && !dl) pulse_done();
      in_token(st, pid);
      checks++; if (st !== 1'b1 || pid !== exp_data_pid(exp_toggle)) begin failures++; $display("FAIL rnd_pid got=%b/%h exp=1/%h", st, pid, exp_data_pid(exp_toggle)); end
      receive();
      compare_packet("rnd");
      if ($urandom_range(0, 2) == 0) begin
        in_token(st, pid);
        checks++; if (pid !== exp_data_pid(exp_toggle)) begin failures++; $display("FAIL rnd_resend_pid got=%h exp=%h", pid, exp_data_pid(exp_toggle)); end
        receive();
        compare_packet("rnd_resend");
      end
      send_ack(a);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL rnd_acked got=%b exp=1", a); end
      exp_toggle = ~exp_toggle;
    end
  endtask

  task automatic test_reset_during_send();
    logic st, a;
    logic [3:0] pid;
    exp_q.delete();
    put_bytes(MAX, 1'b0);
    in_token(st, pid);
    tx_data_get = 1'b1;
    tick();
    tick();
    tx_data_get = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++; if (tx_data_avail !== 1'b0) begin failures++; $display("FAIL async_avail got=%b exp=0", tx_data_avail); end
    checks++; if (tx_pid !== 4'h0) begin failures++; $display("FAIL async_pid got=%h exp=0", tx_pid); end
    checks++; if (tx_pid_start !== 1'b0 || in_ep_acked !== 1'b0) begin failures++; $display("FAIL async_pulses got=%b%b exp=00", tx_pid_start, in_ep_acked); end
    checks++; if (in_ep_data_free !== 1'b1) begin failures++; $display("FAIL async_free got=%b exp=1", in_ep_data_free); end
    @(posedge clk);
    #1 reset = 1'b0;
    exp_toggle = 1'b0;
    checks++; if (in_ep_data_free !== 1'b1) begin failures++; $display("FAIL post_rst_free got=%b exp=1", in_ep_data_free); end
    exp_q.delete();
    put_bytes(1, 1'b1);
    in_token(st, pid);
    checks++; if (pid !== 4'h3) begin failures++; $display("FAIL post_rst_pid got=%h exp=3", pid); end
    receive();
    compare_packet("post_rst");
    send_ack(a);
    exp_toggle = ~exp_toggle;
  endtask

  initial begin
    reset = 1'b1;
    in_ep_data_put = 1'b0; in_ep_data = '0; in_ep_data_done = 1'b0; in_ep_stall = 1'b0;
    in_token_rx = 1'b0; setup_token_rx = 1'b0; ack_rx = 1'b0; tx_data_get = 1'b0;
    exp_toggle = 1'b0;
    test_reset();
    test_basic();
    test_zlp();
    test_nak_and_full();
    test_timeout();
    test_stall();
    test_random_packets();
    test_reset_during_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
